// File: rtl/wrapper_pkg.sv
// Shared types and constants for the valid/ready packet construct wrapper.
package wrapper_pkg;
  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int calc_idxw(input int packet_width);
    return $clog2(packet_width / WORD_WIDTH);
  endfunction
endpackage

// File: rtl/wrapper_vr_out_stage.sv
// Single-entry registered valid/ready stage; holds data stable until handshake.
module wrapper_vr_out_stage
  import wrapper_pkg::*;
#(
  parameter int W = 513
) (
  input  logic         hclk,
  input  logic         hresetn,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  out_state_e   state_q, state_d;
  logic [W-1:0] data_q;
  logic         load;

  // Accept a new entry when empty or when the current one leaves this edge.
  assign in_ready_o  = (state_q == EMPTY) | out_ready_i;
  assign load        = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready_i & ~load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= in_data_i;
    end
  end
endmodule

// File: rtl/wrapper_vr_packet_construct.sv
// Assembles 32-bit strobed register writes into PACKETWIDTH-bit packets and
// streams them to the engine through a registered valid/ready stage.
module wrapper_vr_packet_construct
  import wrapper_pkg::*;
#(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 512
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic                   read_en,
  input  logic                   write_en,
  input  logic [3:0]             byte_strobe,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   wready,
  output logic                   rready,
  output logic [PACKETWIDTH-1:0] data_out,
  output logic                   data_out_last,
  output logic                   data_out_valid,
  input  logic                   data_out_ready
);
  localparam int WORDS = PACKETWIDTH / WORD_WIDTH;
  localparam int IDXW  = calc_idxw(PACKETWIDTH);

  if (ADDRWIDTH < IDXW + 3) begin : g_addr_chk
    $error("ADDRWIDTH too small for PACKETWIDTH word index plus last alias");
  end

  logic [WORDS-1:0][WORD_WIDTH-1:0] asm_q, asm_d;
  logic                             asm_full_q, asm_full_d;
  logic                             asm_last_q, asm_last_d;
  logic [IDXW-1:0]                  idx;
  logic                             wr_acc, in_ready, xfer;
  logic                             unused_in;

  assign idx       = addr[IDXW+1:2];
  assign wready    = ~asm_full_q;
  assign wr_acc    = write_en & ~asm_full_q;
  assign xfer      = asm_full_q & in_ready;
  assign rdata     = asm_q[idx];
  assign rready    = 1'b1;
  assign unused_in = ^{addr, read_en};

  // Writes are blocked while full and transfers need full, so both never coincide.
  always_comb begin
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    asm_last_d = asm_last_q;
    if (xfer) begin
      asm_d      = '0;
      asm_full_d = 1'b0;
      asm_last_d = 1'b0;
    end else if (wr_acc) begin
      for (int b = 0; b < BYTES_PER_WORD; b++)
        if (byte_strobe[b]) asm_d[idx][8*b +: 8] = wdata[8*b +: 8];
      if (idx == IDXW'(WORDS - 1)) begin
        asm_full_d = 1'b1;
        asm_last_d = addr[ADDRWIDTH-1];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      asm_last_q <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      asm_last_q <= asm_last_d;
    end
  end

  wrapper_vr_out_stage #(.W(PACKETWIDTH + 1)) u_out (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .in_data_i   ({asm_last_q, asm_q}),
    .in_valid_i  (asm_full_q),
    .in_ready_o  (in_ready),
    .out_data_o  ({data_out_last, data_out}),
    .out_valid_o (data_out_valid),
    .out_ready_i (data_out_ready)
  );
endmodule

// File: tb/tb_wrapper_vr_packet_construct.sv
// Self-checking bench: packet-level reference model, strobe vector table,
// directed back-pressure/last/reset sequences and randomized traffic.
module tb_wrapper_vr_packet_construct;
  localparam int AW = 11, PW = 512, WORDS = 16;
  typedef logic [PW:0] pkt_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   pre, d;
    logic [3:0]    s;
    logic [31:0]   expw;
  } vec_t;

  logic hclk = 1'b0, hresetn = 1'b0;
  logic [AW-1:0] addr = '0;
  logic read_en = 0, write_en = 0, data_out_ready = 0;
  logic [3:0] byte_strobe = '0;
  logic [31:0] wdata = '0, rdata;
  logic wready, rready, data_out_last, data_out_valid;
  logic [PW-1:0] data_out;

  int n_chk = 0, n_pass = 0, stab_viol = 0;
  pkt_t exp_q[$], rcv_q[$];
  logic [31:0] mbuf[WORDS];
  vec_t tbl[6];

  always #5 hclk = ~hclk;

  wrapper_vr_packet_construct #(.ADDRWIDTH(AW), .PACKETWIDTH(PW)) dut (
    .hclk(hclk), .hresetn(hresetn), .addr(addr), .read_en(read_en),
    .write_en(write_en), .byte_strobe(byte_strobe), .wdata(wdata),
    .rdata(rdata), .wready(wready), .rready(rready), .data_out(data_out),
    .data_out_last(data_out_last), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  task automatic chk(input string name, input pkt_t act, input pkt_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Reference: a packet is the 16 words as last written; the final word closes it.
  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    pkt_t p;
    i = int'(a[5:2]);
    for (int b = 0; b < 4; b++) if (s[b]) mbuf[i][8*b +: 8] = d[8*b +: 8];
    if (i == WORDS - 1) begin
      for (int k = 0; k < WORDS; k++) p[32*k +: 32] = mbuf[k];
      p[PW] = a[AW-1];
      exp_q.push_back(p);
      for (int k = 0; k < WORDS; k++) mbuf[k] = '0;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input bit rnd);
    int t;
    t = 0;
    @(negedge hclk);
    addr = a; wdata = d; byte_strobe = s; write_en = 1'b1;
    while (!wready) begin
      if (rnd) data_out_ready = 1'($urandom_range(0, 1));
      @(negedge hclk);
      t++;
      if (t > 200) begin
        n_chk++;
        $display("FAIL wr_timeout: addr %0h still stalled, wready %0b want 1", a, wready);
        write_en = 1'b0;
        return;
      end
    end
    @(posedge hclk);
    model_write(a, d, s);
    #1 write_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string name);
    @(negedge hclk);
    addr = a; read_en = 1'b1;
    #1;
    chk(name, rdata, e);
    chk("rready", rready, 1'b1);
    read_en = 1'b0;
  endtask

  task automatic drain();
    pkt_t p;
    while (rcv_q.size() > 0) begin
      p = rcv_q.pop_front();
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pkt_unexpected: got %0h want none", p);
      end else chk("pkt", p, exp_q.pop_front());
    end
  endtask

  initial begin
    pkt_t pa, pb;
    logic [AW-1:0] ra;
    tbl[0] = '{11'h000, 32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    tbl[1] = '{11'h004, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 32'hFF000000};
    tbl[2] = '{11'h008, 32'hDEADBEEF, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
    tbl[3] = '{11'h00C, 32'h12345678, 32'h9ABCDEF0, 4'b0000, 32'h12345678};
    tbl[4] = '{11'h010, 32'h01020304, 32'hA0B0C0D0, 4'b0110, 32'h01B0C004};
    tbl[5] = '{11'h014, 32'hFFFFFFFF, 32'h00000000, 4'b0011, 32'hFFFF0000};
    for (int k = 0; k < WORDS; k++) mbuf[k] = '0;

    // Handshake monitor plus hold-stability tracker, same process as stimulus.
    fork
      begin
        bit   held;
        pkt_t hd;
        held = 0;
        forever begin
          @(posedge hclk);
          if (hresetn && held && (!data_out_valid || {data_out_last, data_out} !== hd)) stab_viol++;
          if (hresetn && data_out_valid && data_out_ready) rcv_q.push_back({data_out_last, data_out});
          held = hresetn && data_out_valid && !data_out_ready;
          hd   = {data_out_last, data_out};
        end
      end
    join_none

    // Reset state
    @(negedge hclk);
    chk("rst_valid", data_out_valid, 1'b0);
    chk("rst_wready", wready, 1'b1);
    chk("rst_rready", rready, 1'b1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_data", {data_out_last, data_out}, '0);
    @(negedge hclk) hresetn = 1'b1;

    // Basic packet, latency and content
    data_out_ready = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      if (k > 0) chk("wready_idle", wready, 1'b1);
      wr(11'(k * 4), 32'(k), 4'hF, 0);
    end
    chk("lat_full_valid", data_out_valid, 1'b0);
    chk("lat_full_wready", wready, 1'b0);
    @(posedge hclk); #1;
    chk("lat_valid", data_out_valid, 1'b1);
    chk("lat_last", data_out_last, 1'b0);
    chk("lat_wready", wready, 1'b1);
    for (int k = 0; k < WORDS; k++) chk($sformatf("pkt1_w%0d", k), data_out[32*k +: 32], 32'(k));
    repeat (2) @(negedge hclk);
    drain();

    // Strobe table with readback
    for (int v = 0; v < 6; v++) begin
      wr(tbl[v].a, tbl[v].pre, 4'hF, 0);
      wr(tbl[v].a, tbl[v].d, tbl[v].s, 0);
      rd(tbl[v].a, tbl[v].expw, $sformatf("tbl%0d_rd", v));
    end
    wr(11'h03C, 32'h0F0F0F0F, 4'hF, 0);
    rd(11'h008, 32'hCAFEF00D, "rd_full");
    repeat (3) @(negedge hclk);
    rd(11'h008, 32'h0, "rd_after_xfer");
    drain();

    // Back-pressure: two packets queued, third write stalls
    @(negedge hclk) data_out_ready = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      pa[32*k +: 32] = 32'h100 + 32'(k);
      pb[32*k +: 32] = 32'h200 + 32'(k);
    end
    pa[PW] = 1'b0; pb[PW] = 1'b0;
    for (int k = 0; k < WORDS; k++) wr(11'(k * 4), 32'h100 + 32'(k), 4'hF, 0);
    for (int k = 0; k < WORDS; k++) wr(11'(k * 4), 32'h200 + 32'(k), 4'hF, 0);
    @(negedge hclk);
    chk("bp_wready", wready, 1'b0);
    chk("bp_valid", data_out_valid, 1'b1);
    addr = 11'h000; wdata = 32'h333; byte_strobe = 4'hF; write_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge hclk);
      chk("bp_stall", wready, 1'b0);
      chk("bp_hold", {data_out_last, data_out}, pa);
    end
    data_out_ready = 1'b1;
    @(posedge hclk); #1;
    chk("bp_reload_valid", data_out_valid, 1'b1);
    chk("bp_reload", {data_out_last, data_out}, pb);
    chk("bp_wready_back", wready, 1'b1);
    write_en = 1'b0;
    wr(11'h000, 32'h333, 4'hF, 0);
    repeat (2) @(negedge hclk);
    drain();

    // Last flag from addr bit 10 on the completing write only
    for (int k = 1; k < WORDS - 1; k++) wr(11'(k * 4), 32'h400 + 32'(k), 4'hF, 0);
    wr(11'h43C, 32'h40F, 4'hF, 0);
    @(posedge hclk); #1;
    chk("last_set", {data_out_valid, data_out_last}, 2'b11);
    for (int k = 0; k < WORDS; k++) wr(11'(k * 4), 32'h500 + 32'(k), 4'hF, 0);
    @(posedge hclk); #1;
    chk("last_clear", {data_out_valid, data_out_last}, 2'b10);
    repeat (2) @(negedge hclk);
    drain();

    // Reset with a pending packet and a partial assembly
    @(negedge hclk) data_out_ready = 1'b0;
    for (int k = 0; k < WORDS; k++) wr(11'(k * 4), 32'h600 + 32'(k), 4'hF, 0);
    for (int k = 0; k < 7; k++) wr(11'(k * 4), 32'hFFFF_0700 + 32'(k), 4'hF, 0);
    @(negedge hclk);
    chk("pre_rst_valid", data_out_valid, 1'b1);
    hresetn = 1'b0; addr = 11'h004;
    #1;
    chk("mid_rst_valid", data_out_valid, 1'b0);
    chk("mid_rst_wready", wready, 1'b1);
    chk("mid_rst_rdata", rdata, 32'h0);
    drain();
    exp_q.delete();
    for (int k = 0; k < WORDS; k++) mbuf[k] = '0;
    @(negedge hclk) hresetn = 1'b1;
    data_out_ready = 1'b1;
    for (int k = 0; k < WORDS; k++) wr(11'(k * 4), 32'h800 + 32'(k), (k < 7) ? 4'b0001 : 4'hF, 0);
    repeat (3) @(negedge hclk);
    chk("rst_pkts", rcv_q.size(), 1);
    drain();

    // Randomized traffic against the packet model
    for (int n = 0; n < 300; n++) begin
      data_out_ready = ($urandom_range(0, 3) != 0);
      ra = {1'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        @(negedge hclk);
        addr = ra; read_en = 1'b1;
        #1;
        if (wready) chk("rnd_rd", rdata, mbuf[int'(ra[5:2])]);
        read_en = 1'b0;
      end else wr(ra, $urandom, 4'($urandom), 1);
    end
    @(negedge hclk) data_out_ready = 1'b1;
    repeat (6) @(negedge hclk);
    drain();
    chk("all_pkts_out", exp_q.size(), 0);
    chk("stable_hold", stab_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
